seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Run-time programmable serial bit-pattern detector. It is the parametrised successor to the fixed 5-bit "10010" Mealy detector.
- Pattern length is up to MAX_LEN bits and is set at run time.
- Match mode is selectable between overlapping and non-overlapping.
- Adds a clock-enable, a registered match output and a saturating match counter.
- Sits on a 1-bit serial input stream in the sequential-detector test designs, one bit sampled per enabled clock.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (legal range 2..32).
- CNT_W, 8: match counter width.
- DEFAULT_LEN, 5: pattern length loaded at reset.
- DEFAULT_PAT, 8'b0001_0010: pattern loaded at reset. Only the low DEFAULT_LEN bits are used, which gives 10010.
- LW = $clog2(MAX_LEN+1): derived width of the length fields; not overridable.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- en, input, 1: sample x this cycle.
- x, input, 1: serial data bit.
- cfg_load, input, 1: load a new configuration this cycle.
- cfg_pattern, input, MAX_LEN: new pattern, right-aligned. Bit [len-1] is the first bit received, bit [0] the last.
- cfg_len, input, LW: new pattern length.
- cfg_overlap, input, 1: 1 = overlapping matches allowed, 0 = non-overlapping.
- cnt_clr, input, 1: synchronous clear of match_cnt.
- z, output, 1: combinational (Mealy) match, asserted in the cycle the last pattern bit is on x.
- z_q, output, 1: z registered; z_q = z delayed one cycle.
- match_cnt, output, CNT_W: saturating count of matches.
- cfg_err, output, 1: registered one-cycle pulse flagging a rejected cfg_load.

Behaviour:

Reset values (rst low, asynchronous):
- pat = DEFAULT_PAT, len = DEFAULT_LEN, overlap = 1.
- hist = 0, fill = 0, match_cnt = 0, z_q = 0, cfg_err = 0.

Internal state:
- hist[MAX_LEN-1:0]: shift register; each enabled non-load cycle, hist <= {hist[MAX_LEN-2:0], x}.
- fill: count of valid bits held in hist, saturating at MAX_LEN.

Match condition:
- z = en & ~cfg_load & (fill >= len-1) & (({hist,x} & mask) == (pat & mask)).
- mask holds len ones, right-aligned.
- len = 1 degenerates to z = en & (x == pat[0]).

After a match:
- overlap = 1: fill keeps incrementing, so a suffix of the match can start the next one. Stream 10010010 with pattern 10010 matches on bits 5 and 8.
- overlap = 0: fill <= 0 in the matching cycle (hist still shifts). The next match needs len fresh bits. The same stream matches on bit 5 only.

en:
- en = 0 freezes hist and fill, and forces z = 0.
- match_cnt can still be cleared while en = 0.

cfg_load (takes priority over en):
- Legal load (2 <= cfg_len <= MAX_LEN, or cfg_len = 1): latch pattern, len and overlap; clear hist and fill; z = 0 in that cycle; x is not sampled.
- Illegal load (cfg_len = 0 or cfg_len > MAX_LEN): configuration unchanged, hist and fill are still cleared, cfg_err = 1 in the next cycle.
- cfg_err is otherwise 0.

match_cnt:
- Increments on each cycle with z = 1; saturates at 2^CNT_W-1, with no wrap.
- cnt_clr has priority: if cnt_clr and z occur in the same cycle, match_cnt becomes 0 (that match is not counted).

z_q <= z each cycle, irrespective of en.

Reset mid-stream: all state returns to the reset values immediately, and any partially received pattern is lost.

Decomposition:
- Package seq_det_pkg holds:
  - defaults DEFAULT_LEN and DEFAULT_PAT;
  - the mode encoding constants OVL_ON and OVL_OFF;
  - function len_mask(len), which returns the right-aligned ones mask of MAX_LEN bits.
- One sub-module: sat_counter #(W), with clk, rst, clr, inc, and output q. It saturates, and clr wins over inc.

Test Plan:
1. Reset defaults: after reset, stream 1,0,0,1,0 with en=1 → z=1 on the 5th bit only; z_q=1 the next cycle; match_cnt=1.
2. Overlap mode: default pattern, stream 10010010 → z on bits 5 and 8, match_cnt=2. Then load overlap=0 with the same pattern and replay the stream → z on bit 5 only, match_cnt=3.
3. Reconfigure: load cfg_pattern=8'b1011_0110, cfg_len=8 → stream 10110110 matches on bit 8. Then load cfg_len=9 → cfg_err pulses 1 cycle, pattern 10110110 is retained, and a fresh 8-bit stream still matches.
4. Enable gating: split the stream 10010 with en=0 gaps of 3 cycles between bits (x toggling randomly during the gaps) → exactly one match, on the 5th enabled bit; z=0 in every en=0 cycle.
5. Counter: set CNT_W=2 and drive 5 matches → match_cnt saturates at 3. Assert cnt_clr in the same cycle as a match → match_cnt=0.
6. Reset mid-stream: send 1001, assert rst for 1 cycle, send 0 → no match. Then send 10010 → match on the 5th bit.

Source files
------------

// File: rtl/seq_detector_param_pkg.sv
// seq_det_pkg: shared defaults, overlap-mode encoding and mask helper for seq_detector_param
package seq_det_pkg;
  localparam int DEFAULT_LEN = 5;
  localparam logic [7:0] DEFAULT_PAT = 8'b0001_0010;
  localparam logic OVL_ON = 1'b1;
  localparam logic OVL_OFF = 1'b0;
  localparam int MASK_W = 32;
  function automatic logic [MASK_W-1:0] len_mask(input logic [5:0] len);
    logic [MASK_W:0] m;
    m = ({{MASK_W{1'b0}}, 1'b1} << len) - {{MASK_W{1'b0}}, 1'b1};
    return m[MASK_W-1:0];
  endfunction
endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that wins over increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
  end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial pattern detector with Mealy match and saturating counter
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  parameter int DEFAULT_LEN = seq_det_pkg::DEFAULT_LEN,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(seq_det_pkg::DEFAULT_PAT),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic               z_q,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);
  import seq_det_pkg::*;
  logic [MAX_LEN-1:0] pat, hist, mask, win;
  logic [LW-1:0] len, fill;
  logic ovl, legal;
  assign mask = MAX_LEN'(len_mask(6'(len)));
  assign win = {hist[MAX_LEN-2:0], x};
  assign legal = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
  // fill counts bits already in hist, so the current x supplies the last one
  assign z = en & ~cfg_load & (fill >= len - 1'b1) & ((win & mask) == (pat & mask));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat <= DEFAULT_PAT;
      len <= LW'(DEFAULT_LEN);
      ovl <= OVL_ON;
      hist <= '0;
      fill <= '0;
      z_q <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      z_q <= z;
      cfg_err <= cfg_load & ~legal;
      if (cfg_load) begin
        hist <= '0;
        fill <= '0;
        if (legal) begin
          pat <= cfg_pattern;
          len <= cfg_len;
          ovl <= cfg_overlap;
        end
      end else if (en) begin
        hist <= win;
        fill <= (z && ovl == OVL_OFF) ? '0 : (fill == LW'(MAX_LEN)) ? fill : fill + 1'b1;
      end
    end
  end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(z),
    .q(match_cnt)
  );
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: vector table, directed corner sequences and random stream vs queue-based model
module tb_seq_detector_param;
  logic clk = 0, rst = 0, en = 0, x = 0, cfg_load = 0, cfg_overlap = 0, cnt_clr = 0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic z, z_q, cfg_err;
  logic [1:0] match_cnt;

  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z), .z_q(z_q), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] m_pat;
  int m_len, m_cnt;
  bit m_ovl, m_zq, m_err, last_z;
  bit m_q[$];

  typedef struct {
    logic e, xx, cc, ez;
    logic [1:0] ecnt;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: bits received since last reset/load/non-overlapping match, newest last
  function automatic bit model_z(input logic e, input logic xx, input logic ld);
    bit b;
    if (!e || ld || m_q.size() < m_len - 1) return 0;
    for (int i = 0; i < m_len; i++) begin
      b = (i == 0) ? xx : m_q[m_q.size() - i];
      if (b != m_pat[i]) return 0;
    end
    return 1;
  endfunction

  task automatic model_reset();
    m_pat = 8'b0001_0010; m_len = 5; m_ovl = 1;
    m_q.delete(); m_cnt = 0; m_zq = 0; m_err = 0;
  endtask

  task automatic step(input logic e, input logic xx, input logic ld, input logic [7:0] cp,
                      input logic [3:0] cl, input logic co, input logic cc);
    bit zx, legal;
    en = e; x = xx; cfg_load = ld; cfg_pattern = cp; cfg_len = cl; cfg_overlap = co; cnt_clr = cc;
    #3;
    zx = model_z(e, xx, ld);
    chk("z", z, zx);
    chk("match_cnt", match_cnt, m_cnt);
    chk("z_q", z_q, m_zq);
    chk("cfg_err", cfg_err, m_err);
    last_z = z;
    if (ld) begin
      legal = (cl >= 1) && (cl <= 8);
      if (legal) begin m_pat = cp; m_len = cl; m_ovl = co; end
      m_q.delete();
      m_err = !legal;
    end else begin
      m_err = 0;
      if (e) begin
        if (zx && !m_ovl) m_q.delete();
        else begin
          m_q.push_back(xx);
          if (m_q.size() > 8) void'(m_q.pop_front());
        end
      end
    end
    m_cnt = cc ? 0 : (zx && m_cnt < 3) ? m_cnt + 1 : m_cnt;
    m_zq = zx;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] bits, input int n, output logic [31:0] hm);
    hm = '0;
    for (int i = 0; i < n; i++) begin
      step(1, bits[n-1-i], 0, 8'h0, 4'h0, 0, 0);
      hm[i] = last_z;
    end
  endtask

  task automatic do_reset();
    en = 0; cfg_load = 0; cnt_clr = 0; rst = 0;
    #1;
    chk("rst_z", z, 0);
    chk("rst_z_q", z_q, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_cfg_err", cfg_err, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1;
  endtask

  initial begin
    logic [31:0] hm;
    int r;
    logic [3:0] cl;
    tv = '{
      '{1, 1, 0, 0, 2'd0}, '{1, 0, 0, 0, 2'd0}, '{1, 0, 0, 0, 2'd0}, '{1, 1, 0, 0, 2'd0},
      '{1, 0, 0, 1, 2'd1}, '{1, 0, 0, 0, 2'd1}, '{1, 1, 0, 0, 2'd1}, '{1, 0, 0, 1, 2'd2},
      '{0, 1, 0, 0, 2'd2}, '{0, 0, 0, 0, 2'd2}
    };
    @(posedge clk); #1;
    do_reset();
    foreach (tv[i]) begin
      step(tv[i].e, tv[i].xx, 0, 8'h0, 4'h0, 0, tv[i].cc);
      chk("tv_z", last_z, tv[i].ez);
      chk("tv_cnt", match_cnt, tv[i].ecnt);
    end
    step(0, 0, 1, 8'b0001_0010, 4'd5, 0, 0);
    send(32'b10010010, 8, hm);
    chk("nonovl_hits", hm, 32'h10);
    chk("nonovl_cnt", match_cnt, 3);
    step(0, 0, 1, 8'b1011_0110, 4'd8, 1, 1);
    send(32'b10110110, 8, hm);
    chk("len8_hits", hm, 32'h80);
    step(0, 0, 1, 8'hFF, 4'd9, 1, 0);
    chk("cfg_err_pulse", cfg_err, 1);
    step(0, 0, 0, 8'h0, 4'h0, 0, 0);
    chk("cfg_err_clear", cfg_err, 0);
    send(32'b10110110, 8, hm);
    chk("retained_hits", hm, 32'h80);
    step(0, 0, 1, 8'b0001_0010, 4'd5, 1, 1);
    hm = '0;
    for (int i = 0; i < 5; i++) begin
      step(1, (5'b10010 >> (4 - i)) & 1'b1, 0, 8'h0, 4'h0, 0, 0);
      hm[i] = last_z;
      for (int g = 0; g < 3; g++) begin
        step(0, 1'($urandom), 0, 8'h0, 4'h0, 0, 0);
        chk("gap_z", last_z, 0);
      end
    end
    chk("gated_hits", hm, 32'h10);
    step(0, 0, 0, 8'h0, 4'h0, 0, 1);
    send(32'h12492, 17, hm);
    chk("sat_hits", hm, 32'h12490);
    chk("sat_cnt", match_cnt, 3);
    step(1, 0, 0, 8'h0, 4'h0, 0, 0);
    step(1, 1, 0, 8'h0, 4'h0, 0, 0);
    step(1, 0, 0, 8'h0, 4'h0, 0, 1);
    chk("clr_match_z", last_z, 1);
    chk("clr_match_cnt", match_cnt, 0);
    send(32'b1001, 4, hm);
    do_reset();
    send(32'b0, 1, hm);
    chk("midrst_hits", hm, 0);
    send(32'b10010, 5, hm);
    chk("postrst_hits", hm, 32'h10);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      if (r == 0) do_reset();
      else if (r < 6) begin
        cl = $urandom_range(0, 1) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
        step(1'($urandom), 1'($urandom), 1, 8'($urandom), cl, 1'($urandom), 0);
      end else
        step(r % 8 != 0, 1'($urandom), 0, 8'($urandom), 4'($urandom), 1'($urandom),
             $urandom_range(0, 59) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
